// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - shared types and constants for the multicycle sequencer
//
// Purpose : state encoding, ALU operation codes, RV32I opcode constants and
//           datapath mux-select values shared by the sequencer, its ALU
//           decoder and the control interface.
// Ports   : none (package).

package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_BOOT     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECR    = 4'd7,
      S_EXECI    = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10,
      S_JALRADR  = 4'd11,
      S_JAL      = 4'd12,
      S_LUI      = 4'd13,
      S_AUIPC    = 4'd14,
      S_TRAP     = 4'd15
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_t;

   // How the sequencer asks the ALU decoder for an operation: fixed ADD/SUB/
   // PASS_B for address and flag computations, or a funct-field decode.
   typedef enum logic [1:0] {
      MODE_ADD    = 2'd0,
      MODE_SUB    = 2'd1,
      MODE_FUNCT  = 2'd2,
      MODE_PASS_B = 2'd3
   } alu_mode_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RD1    = 2'b10;

   localparam logic [1:0] SRC_B_RD2    = 2'b00;
   localparam logic [1:0] SRC_B_IMM    = 2'b01;
   localparam logic [1:0] SRC_B_FOUR   = 2'b10;

   localparam logic [1:0] RES_ALU_REG  = 2'b00;
   localparam logic [1:0] RES_DATA     = 2'b01;
   localparam logic [1:0] RES_ALU      = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Branch condition from funct3 and the ALU flags of rs1 - rs2.
   // funct3 010/011 are not branch encodings and are never taken.
   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic zero,
                                         input logic lt,
                                         input logic ltu);
      logic taken;
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = lt;
         3'b101:  taken = !lt;
         3'b110:  taken = ltu;
         3'b111:  taken = !ltu;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - control bundle between sequencer and datapath
//
// Purpose : carries instruction fields and ALU flags into the sequencer and
//           every mux select / write enable back out to the datapath.
// Ports   : master (sequencer) - inputs opcode, funct3, funct7b5, zero, lt,
//           ltu, mem_ready; outputs pc_write, adr_src, ir_write, mem_write,
//           reg_write, alu_src_a, alu_src_b, result_src, imm_src,
//           alu_control, instr_retired, trap, state_dbg.
//           slave (datapath) - the same signals with directions reversed.

interface multicycle_sequencer_if;
   import riscv_ctrl_pkg::*;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       lt;
   logic       ltu;
   logic       mem_ready;

   logic       pc_write;
   logic       adr_src;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [2:0] imm_src;
   alu_op_t    alu_control;
   logic       instr_retired;
   logic       trap;
   logic [3:0] state_dbg;

   modport master (
      input  opcode, funct3, funct7b5, zero, lt, ltu, mem_ready,
      output pc_write, adr_src, ir_write, mem_write, reg_write,
             alu_src_a, alu_src_b, result_src, imm_src, alu_control,
             instr_retired, trap, state_dbg
   );

   modport slave (
      output opcode, funct3, funct7b5, zero, lt, ltu, mem_ready,
      input  pc_write, adr_src, ir_write, mem_write, reg_write,
             alu_src_a, alu_src_b, result_src, imm_src, alu_control,
             instr_retired, trap, state_dbg
   );

endinterface

// File: rtl/multicycle_sequencer_alu_decoder.sv
// rtl/multicycle_sequencer_alu_decoder.sv - ALU operation decode for the sequencer
//
// Purpose : maps the sequencer's ALU request plus funct fields to an ALU op.
// Ports   : alu_mode (in, alu_mode_t), funct3 (in, 3), funct7b5 (in, 1),
//           opcode5 (in, 1, instr[5]: 1 for R-type), alu_op (out, alu_op_t).

module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  alu_mode_t  alu_mode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       opcode5,
   output alu_op_t    alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      case (alu_mode)
         MODE_ADD:    alu_op = ALU_ADD;
         MODE_SUB:    alu_op = ALU_SUB;
         MODE_PASS_B: alu_op = ALU_PASS_B;
         default: begin
            case (funct3)
               // funct7b5 of an I-type is immediate bit 10, so SUB only
               // exists for register-register instructions.
               3'b000:  alu_op = (opcode5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - control FSM for the RV32I multicycle core
//
// Purpose : sequences fetch / decode / execute / memory / writeback for the
//           shared-memory datapath, with configurable memory wait states,
//           optional ready handshake, sticky trap and a retire pulse.
// Params  : MEM_WAIT_STATES - extra cycles every memory access holds.
//           USE_MEM_READY   - 1: access also needs mem_ready at completion.
// Ports   : clk (in), reset_n (in, async active-low),
//           bus (multicycle_sequencer_if.master; see interface file).

module multicycle_sequencer
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_STATES = 0,
   parameter bit USE_MEM_READY   = 1'b0
)
(
   input  logic                   clk,
   input  logic                   reset_n,
   multicycle_sequencer_if.master bus
);

   localparam int WW = (MEM_WAIT_STATES > 0) ? $clog2(MEM_WAIT_STATES + 1) : 1;
   localparam logic [WW-1:0] WMAX = WW'(MEM_WAIT_STATES);

   state_t        state;
   state_t        state_next;
   logic [WW-1:0] wcnt;
   logic          acc_done;

   alu_mode_t     alu_mode;
   logic          pc_write;
   logic          adr_src;
   logic          ir_write;
   logic          mem_write;
   logic          reg_write;
   logic [1:0]    alu_src_a;
   logic [1:0]    alu_src_b;
   logic [1:0]    result_src;
   logic [2:0]    imm_src;
   logic          instr_retired;
   logic          trap;

   // Counter runs in every state but only matters in the three access
   // states; clearing it on each transition gives every access a fresh count.
   assign acc_done = (wcnt == WMAX) && (bus.mem_ready || !USE_MEM_READY);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_BOOT;
         wcnt  <= '0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            wcnt <= '0;
         end else if (wcnt != WMAX) begin
            wcnt <= wcnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_BOOT:     state_next = S_FETCH;
         S_FETCH:    if (acc_done) state_next = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD,
               OP_STORE:  state_next = S_MEMADR;
               OP_R:      state_next = S_EXECR;
               OP_I:      state_next = S_EXECI;
               OP_BRANCH: state_next = S_BRANCH;
               OP_JAL:    state_next = S_JAL;
               OP_JALR:   state_next = S_JALRADR;
               OP_LUI:    state_next = S_LUI;
               OP_AUIPC:  state_next = S_AUIPC;
               default:   state_next = S_TRAP;
            endcase
         end
         S_MEMADR:   state_next = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (acc_done) state_next = S_MEMWB;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: if (acc_done) state_next = S_FETCH;
         S_EXECR:    state_next = S_ALUWB;
         S_EXECI:    state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_BRANCH:   state_next = S_FETCH;
         S_JALRADR:  state_next = S_JAL;
         S_JAL:      state_next = S_ALUWB;
         S_LUI:      state_next = S_ALUWB;
         S_AUIPC:    state_next = S_ALUWB;
         S_TRAP:     state_next = S_TRAP;
         default:    state_next = S_BOOT;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RD2;
      result_src    = RES_ALU_REG;
      imm_src       = IMM_I;
      alu_mode      = MODE_ADD;
      instr_retired = 1'b0;
      trap          = 1'b0;
      case (state)
         S_FETCH: begin
            // PC+4 goes straight from the ALU into PC in the same cycle the
            // instruction word is captured.
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU;
            ir_write   = acc_done;
            pc_write   = acc_done;
         end
         S_DECODE: begin
            // Speculatively form old_pc + B-imm; BRANCH uses it from alu_reg.
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            imm_src   = IMM_B;
         end
         S_MEMADR: begin
            alu_src_a = SRC_A_RD1;
            alu_src_b = SRC_B_IMM;
            imm_src   = bus.opcode[5] ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            adr_src    = 1'b1;
            result_src = RES_ALU_REG;
         end
         S_MEMWB: begin
            result_src    = RES_DATA;
            reg_write     = 1'b1;
            instr_retired = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src       = 1'b1;
            result_src    = RES_ALU_REG;
            mem_write     = acc_done;
            instr_retired = acc_done;
         end
         S_EXECR: begin
            alu_src_a = SRC_A_RD1;
            alu_src_b = SRC_B_RD2;
            alu_mode  = MODE_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRC_A_RD1;
            alu_src_b = SRC_B_IMM;
            imm_src   = IMM_I;
            alu_mode  = MODE_FUNCT;
         end
         S_ALUWB: begin
            result_src    = RES_ALU_REG;
            reg_write     = 1'b1;
            instr_retired = 1'b1;
         end
         S_BRANCH: begin
            // Compare rs1 - rs2 while alu_reg still holds the target.
            alu_src_a     = SRC_A_RD1;
            alu_src_b     = SRC_B_RD2;
            alu_mode      = MODE_SUB;
            result_src    = RES_ALU_REG;
            pc_write      = branch_taken(bus.funct3, bus.zero, bus.lt, bus.ltu);
            instr_retired = 1'b1;
         end
         S_JALRADR: begin
            alu_src_a = SRC_A_RD1;
            alu_src_b = SRC_B_IMM;
            imm_src   = IMM_I;
         end
         S_JAL: begin
            // Jump to the target in alu_reg and compute the link old_pc + 4,
            // which ALUWB then writes to rd.
            alu_src_a  = SRC_A_OLD_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU_REG;
            pc_write   = 1'b1;
         end
         S_LUI: begin
            alu_src_b = SRC_B_IMM;
            imm_src   = IMM_U;
            alu_mode  = MODE_PASS_B;
         end
         S_AUIPC: begin
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            imm_src   = IMM_U;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: begin
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_mode (alu_mode),
      .funct3   (bus.funct3),
      .funct7b5 (bus.funct7b5),
      .opcode5  (bus.opcode[5]),
      .alu_op   (bus.alu_control)
   );

   assign bus.pc_write      = pc_write;
   assign bus.adr_src       = adr_src;
   assign bus.ir_write      = ir_write;
   assign bus.mem_write     = mem_write;
   assign bus.reg_write     = reg_write;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.result_src    = result_src;
   assign bus.imm_src       = imm_src;
   assign bus.instr_retired = instr_retired;
   assign bus.trap          = trap;
   assign bus.state_dbg     = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - self-checking bench for multicycle_sequencer

module tb_multicycle_sequencer;
   import riscv_ctrl_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       irw;
      logic       memw;
      logic       regw;
      logic       ret;
      logic       trp;
      logic       adr;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] res;
      logic [2:0] imm;
      logic [3:0] alu;
   } exp_t;

   logic clk = 1'b0;
   logic rst0_n;
   logic rst1_n;

   int tests = 0;
   int fails = 0;

   exp_t exp_q[$];
   exp_t trace_q[$];
   exp_t cur;

   multicycle_sequencer_if bus0 ();
   multicycle_sequencer_if bus1 ();

   multicycle_sequencer #(.MEM_WAIT_STATES(0), .USE_MEM_READY(1'b0)) dut0 (
      .clk     (clk),
      .reset_n (rst0_n),
      .bus     (bus0)
   );

   multicycle_sequencer #(.MEM_WAIT_STATES(2), .USE_MEM_READY(1'b1)) dut1 (
      .clk     (clk),
      .reset_n (rst1_n),
      .bus     (bus1)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endfunction

   function automatic exp_t ph(input logic [3:0] st, input logic [1:0] a, input logic [1:0] b,
                               input logic [3:0] alu, input logic [1:0] res,
                               input logic [2:0] imm, input logic adr);
      exp_t e;
      e     = '0;
      e.st  = st;
      e.a   = a;
      e.b   = b;
      e.alu = alu;
      e.res = res;
      e.imm = imm;
      e.adr = adr;
      return e;
   endfunction

   function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
      case (f3)
         3'd0:    return (is_r && f7) ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return f7 ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
      case (f3)
         3'd0:    return z;
         3'd1:    return !z;
         3'd4:    return l;
         3'd5:    return !l;
         3'd6:    return lu;
         3'd7:    return !lu;
         default: return 1'b0;
      endcase
   endfunction

   // Cycle-by-cycle expected outputs of one instruction, zero wait states.
   task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input logic l, input logic lu);
      exp_t e;
      trace_q.delete();
      e = ph(S_FETCH, 2'd0, 2'd2, ALU_ADD, 2'd2, 3'd0, 1'b0);
      e.irw = 1'b1;
      e.pcw = 1'b1;
      trace_q.push_back(e);
      trace_q.push_back(ph(S_DECODE, 2'd1, 2'd1, ALU_ADD, 2'd0, 3'd2, 1'b0));
      case (op)
         7'b0000011: begin
            trace_q.push_back(ph(S_MEMADR, 2'd2, 2'd1, ALU_ADD, 2'd0, 3'd0, 1'b0));
            trace_q.push_back(ph(S_MEMREAD, 2'd0, 2'd0, ALU_ADD, 2'd0, 3'd0, 1'b1));
            e = ph(S_MEMWB, 2'd0, 2'd0, ALU_ADD, 2'd1, 3'd0, 1'b0);
            e.regw = 1'b1;
            e.ret  = 1'b1;
            trace_q.push_back(e);
         end
         7'b0100011: begin
            trace_q.push_back(ph(S_MEMADR, 2'd2, 2'd1, ALU_ADD, 2'd0, 3'd1, 1'b0));
            e = ph(S_MEMWRITE, 2'd0, 2'd0, ALU_ADD, 2'd0, 3'd0, 1'b1);
            e.memw = 1'b1;
            e.ret  = 1'b1;
            trace_q.push_back(e);
         end
         7'b0110011, 7'b0010011: begin
            if (op[5]) trace_q.push_back(ph(S_EXECR, 2'd2, 2'd0, ref_alu(f3, f7, 1'b1), 2'd0, 3'd0, 1'b0));
            else       trace_q.push_back(ph(S_EXECI, 2'd2, 2'd1, ref_alu(f3, f7, 1'b0), 2'd0, 3'd0, 1'b0));
         end
         7'b1100011: begin
            e = ph(S_BRANCH, 2'd2, 2'd0, ALU_SUB, 2'd0, 3'd0, 1'b0);
            e.pcw = ref_taken(f3, z, l, lu);
            e.ret = 1'b1;
            trace_q.push_back(e);
         end
         7'b1100111, 7'b1101111: begin
            if (op[3] == 1'b0)
               trace_q.push_back(ph(S_JALRADR, 2'd2, 2'd1, ALU_ADD, 2'd0, 3'd0, 1'b0));
            e = ph(S_JAL, 2'd1, 2'd2, ALU_ADD, 2'd0, 3'd0, 1'b0);
            e.pcw = 1'b1;
            trace_q.push_back(e);
         end
         default: begin
            for (int i = 0; i < 20; i++) begin
               e = ph(S_TRAP, 2'd0, 2'd0, ALU_ADD, 2'd0, 3'd0, 1'b0);
               e.trp = 1'b1;
               trace_q.push_back(e);
            end
         end
      endcase
      // Register-writing ALU-path instructions all finish in ALUWB.
      if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b1101111) begin
         e = ph(S_ALUWB, 2'd0, 2'd0, ALU_ADD, 2'd0, 3'd0, 1'b0);
         e.regw = 1'b1;
         e.ret  = 1'b1;
         trace_q.push_back(e);
      end
   endtask

   // Single compare process for the zero-wait instance.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         chk("state",       bus0.state_dbg,     cur.st);
         chk("pc_write",    bus0.pc_write,      cur.pcw);
         chk("ir_write",    bus0.ir_write,      cur.irw);
         chk("mem_write",   bus0.mem_write,     cur.memw);
         chk("reg_write",   bus0.reg_write,     cur.regw);
         chk("retired",     bus0.instr_retired, cur.ret);
         chk("trap",        bus0.trap,          cur.trp);
         chk("adr_src",     bus0.adr_src,       cur.adr);
         chk("alu_src_a",   bus0.alu_src_a,     cur.a);
         chk("alu_src_b",   bus0.alu_src_b,     cur.b);
         chk("result_src",  bus0.result_src,    cur.res);
         chk("imm_src",     bus0.imm_src,       cur.imm);
         chk("alu_control", bus0.alu_control,   cur.alu);
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      #1;
   endtask

   task automatic run0(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic l, input logic lu, input bit with_boot);
      bus0.opcode   = op;
      bus0.funct3   = f3;
      bus0.funct7b5 = f7;
      bus0.zero     = z;
      bus0.lt       = l;
      bus0.ltu      = lu;
      build(op, f3, f7, z, l, lu);
      if (with_boot) exp_q.push_back('0);
      foreach (trace_q[i]) exp_q.push_back(trace_q[i]);
      wait_drain();
   endtask

   initial begin
      logic [3:0] st2 [11];
      logic [3:0] st6 [9];
      int irw_cnt;
      int ret_cnt;

      st2 = '{S_BOOT, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
              S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
      st6 = '{S_BOOT, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEMADR,
              S_MEMWRITE, S_MEMWRITE, S_MEMWRITE};

      rst0_n = 1'b0;
      rst1_n = 1'b0;
      bus0.opcode = '0; bus0.funct3 = '0; bus0.funct7b5 = 1'b0;
      bus0.zero = 1'b0; bus0.lt = 1'b0; bus0.ltu = 1'b0; bus0.mem_ready = 1'b0;
      bus1.opcode = '0; bus1.funct3 = '0; bus1.funct7b5 = 1'b0;
      bus1.zero = 1'b0; bus1.lt = 1'b0; bus1.ltu = 1'b0; bus1.mem_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", bus0.state_dbg, S_BOOT);
      chk("reset_pc_write", bus0.pc_write, 0);
      chk("reset_trap", bus0.trap, 0);

      // add x3,x1,x2 = 0x002081B3
      rst0_n = 1'b1;
      run0(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("pin_add_len", trace_q.size(), 4);
      chk("pin_add_alu", trace_q[2].alu, ALU_ADD);
      chk("pin_add_regw", trace_q[3].regw, 1);

      run0(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // sub
      chk("pin_sub_alu", trace_q[2].alu, ALU_SUB);
      run0(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // addi, imm bit 10 set
      chk("pin_addi_alu", trace_q[2].alu, ALU_ADD);
      run0(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // srai
      run0(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // and
      run0(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // lw
      run0(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // sw
      run0(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // beq, zero=1
      chk("pin_beq_taken", trace_q[2].pcw, 1);
      run0(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // bne, zero=1
      chk("pin_bne_taken", trace_q[2].pcw, 0);
      run0(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // blt, lt=1
      run0(7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  // bgeu, ltu=1
      run0(7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // non-branch funct3
      run0(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // jalr
      chk("pin_jalr_len", trace_q.size(), 5);
      run0(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // jal
      run0(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // illegal -> trap
      chk("pin_trap_len", trace_q.size(), 22);

      rst0_n = 1'b0;
      #1;
      chk("trap_reset_state", bus0.state_dbg, S_BOOT);
      chk("trap_reset_trap", bus0.trap, 0);
      @(negedge clk);
      chk("trap_reset_hold", bus0.state_dbg, S_BOOT);
      @(posedge clk);
      #1;
      rst0_n = 1'b1;

      // Two wait states with ready handshake: lw, ready low three FETCH cycles.
      bus1.opcode = 7'b0000011;
      bus1.funct3 = 3'b010;
      rst1_n = 1'b1;
      irw_cnt = 0;
      ret_cnt = 0;
      for (int c = 0; c < 11; c++) begin
         bus1.mem_ready = (c >= 4);
         @(negedge clk);
         chk($sformatf("w2_state_c%0d", c), bus1.state_dbg, st2[c]);
         chk($sformatf("w2_irw_c%0d", c), bus1.ir_write, (c == 4));
         if (bus1.ir_write) irw_cnt++;
         if (bus1.instr_retired) ret_cnt++;
         @(posedge clk);
         #1;
      end
      chk("w2_irw_pulses", irw_cnt, 1);
      chk("w2_retire_pulses", ret_cnt, 1);

      // sw interrupted by reset while its access is still waiting on ready.
      rst1_n = 1'b0;
      @(posedge clk);
      #1;
      rst1_n = 1'b1;
      bus1.opcode = 7'b0100011;
      for (int c = 0; c < 9; c++) begin
         bus1.mem_ready = (c < 6);
         @(negedge clk);
         chk($sformatf("sw_state_c%0d", c), bus1.state_dbg, st6[c]);
         chk($sformatf("sw_memw_c%0d", c), bus1.mem_write, 0);
         @(posedge clk);
         #1;
      end
      rst1_n = 1'b0;
      #1;
      chk("sw_reset_state", bus1.state_dbg, S_BOOT);
      chk("sw_reset_memw", bus1.mem_write, 0);
      @(negedge clk);
      chk("sw_reset_hold", bus1.state_dbg, S_BOOT);
      chk("sw_reset_regw", bus1.reg_write, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
